// File: rtl/kf_bus_pkg.sv
// Shared types for the bus-controller / ready-generation slice.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
//
// Holds the ready-generator state encoding, the bus-command classification
// used to pick a wait count, and the width of the wait-state counter.
package kf_bus_pkg;

    // Wait-state counter width; wait counts are limited to 0..15.
    localparam int COUNT_W = 4;

    // Ready-generator sequencing states.
    //   ST_IDLE         : no command in progress, CPU runs at full speed
    //   ST_COUNT        : burning the fixed per-type wait states
    //   ST_WAIT_CHANNEL : fixed waits done, waiting on the I/O channel ready
    //   ST_DONE         : cycle released, holding until the command goes away
    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_COUNT        = 2'd1,
        ST_WAIT_CHANNEL = 2'd2,
        ST_DONE         = 2'd3
    } bus_state_t;

    // Classification of the command currently on the bus.
    typedef enum logic [1:0] {
        BUS_IO   = 2'd0,
        BUS_MEM  = 2'd1,
        BUS_NONE = 2'd2
    } bus_cmd_t;

    // I/O takes precedence over memory when both strobes are asserted, so a
    // malformed overlap always gets the (normally longer) I/O wait count.
    function automatic bus_cmd_t decode_bus_cmd(input logic io_cmd,
                                                input logic mem_cmd);
        bus_cmd_t kind;
        kind = BUS_NONE;
        if (io_cmd) begin
            kind = BUS_IO;
        end else if (mem_cmd) begin
            kind = BUS_MEM;
        end
        return kind;
    endfunction

    // States in which the CPU must be held off (READY low).
    function automatic logic state_stalls_cpu(input bus_state_t st);
        return (st == ST_COUNT) || (st == ST_WAIT_CHANNEL);
    endfunction

endpackage

// File: rtl/ready_synchronizer.sv
// Two-flop synchroniser bringing an asynchronous level into the clock domain.
// Latency: two clock rising edges from input change to sync_o change.
// Backpressure: none; free-running, samples every clock.
//
// Ports:
//   clock   : destination-domain clock, rising edge
//   reset   : asynchronous, active-high; both flops load RESET_VALUE
//   async_i : asynchronous level to be synchronised
//   sync_o  : synchronised level
//
// RESET_VALUE defaults to 1 so that a "ready"-style input reads as ready
// while the design comes out of reset rather than spuriously stalling.
module ready_synchronizer #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta_q <= RESET_VALUE;
            sync_q <= RESET_VALUE;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/bus_ready_generator.sv
// Inserts CPU wait states by driving READY from 8288-style command strobes.
// Latency: READY drops on the first cpu_clock fall after the command is seen.
// Backpressure: holds READY low through fixed waits + channel wait/timeout.
//
// Ports:
//   clock                   : system clock, all flops on its rising edge
//   reset                   : asynchronous, active-high
//   cpu_clock               : CPU clock level, sampled on clock
//   io_read_command_n       : active-low I/O read command
//   io_write_command_n      : active-low I/O write command
//   interrupt_acknowledge_n : active-low INTA command
//   memory_read_command_n   : active-low memory read command
//   memory_write_command_n  : active-low memory write command
//   io_channel_ready        : asynchronous external ready, high = ready
//   ready                   : READY to the CPU, registered, moves only on
//                             cpu_clock falling edges (8284-style timing)
//   wait_timeout            : one-clock pulse when the watchdog forces completion
//   bus_busy                : high whenever the sequencer is not idle
//
// The sequencer only advances on cpu_clock rising edges. READY is re-evaluated
// on the following falling edge, so N wait states produce READY = 0 on exactly
// N consecutive CPU rising edges.
module bus_ready_generator
    import kf_bus_pkg::*;
#(
    parameter int IO_WAIT_STATES  = 1,
    parameter int MEM_WAIT_STATES = 0,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic cpu_clock,
    input  logic io_read_command_n,
    input  logic io_write_command_n,
    input  logic interrupt_acknowledge_n,
    input  logic memory_read_command_n,
    input  logic memory_write_command_n,
    input  logic io_channel_ready,
    output logic ready,
    output logic wait_timeout,
    output logic bus_busy
);

    // Timeout counter must hold 0..TIMEOUT_CYCLES; keep at least one bit so
    // the datapath stays well formed when the watchdog is disabled.
    localparam int TCOUNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [COUNT_W-1:0]  IO_WAIT_W   = COUNT_W'(IO_WAIT_STATES);
    localparam logic [COUNT_W-1:0]  MEM_WAIT_W  = COUNT_W'(MEM_WAIT_STATES);
    localparam logic [COUNT_W-1:0]  COUNT_ONE   = COUNT_W'(1);
    localparam logic [TCOUNT_W-1:0] TCOUNT_ONE  = TCOUNT_W'(1);
    localparam logic [TCOUNT_W-1:0] TCOUNT_LAST =
        (TIMEOUT_CYCLES > 0) ? TCOUNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic                TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);

    // ------------------------------------------------------------------
    // cpu_clock edge detection (cpu_clock is a level sampled on clock)
    // ------------------------------------------------------------------
    logic prev_cpu_clock_q;
    logic cpu_posedge;
    logic cpu_negedge;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev_cpu_clock_q <= 1'b0;
        end else begin
            prev_cpu_clock_q <= cpu_clock;
        end
    end

    assign cpu_posedge = ~prev_cpu_clock_q &  cpu_clock;
    assign cpu_negedge =  prev_cpu_clock_q & ~cpu_clock;

    // ------------------------------------------------------------------
    // External channel ready synchronisation
    // ------------------------------------------------------------------
    logic ch_rdy;

    ready_synchronizer #(
        .RESET_VALUE (1'b1)
    ) u_ch_rdy_sync (
        .clock   (clock),
        .reset   (reset),
        .async_i (io_channel_ready),
        .sync_o  (ch_rdy)
    );

    // ------------------------------------------------------------------
    // Command decode and wait-count selection
    // ------------------------------------------------------------------
    logic                io_cmd;
    logic                mem_cmd;
    logic                cmd_active;
    bus_cmd_t            cmd_kind;
    logic [COUNT_W-1:0]  sel_wait;

    assign io_cmd     = ~io_read_command_n | ~io_write_command_n | ~interrupt_acknowledge_n;
    assign mem_cmd    = ~memory_read_command_n | ~memory_write_command_n;
    assign cmd_active = io_cmd | mem_cmd;
    assign cmd_kind   = decode_bus_cmd(io_cmd, mem_cmd);

    always_comb begin
        sel_wait = '0;
        case (cmd_kind)
            BUS_IO:  sel_wait = IO_WAIT_W;
            BUS_MEM: sel_wait = MEM_WAIT_W;
            default: sel_wait = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Sequencer: state register
    // ------------------------------------------------------------------
    bus_state_t           state_q;
    bus_state_t           state_d;
    logic [COUNT_W-1:0]   count_q;
    logic [COUNT_W-1:0]   count_d;
    logic [TCOUNT_W-1:0]  tcount_q;
    logic [TCOUNT_W-1:0]  tcount_d;
    logic                 wait_timeout_q;
    logic                 wait_timeout_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            count_q        <= '0;
            tcount_q       <= '0;
            wait_timeout_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            tcount_q       <= tcount_d;
            wait_timeout_q <= wait_timeout_d;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer: next-state logic. Nothing moves except on a CPU rising
    // edge, which keeps the sequencer in lock-step with the CPU T-states.
    // ------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        tcount_d       = tcount_q;
        wait_timeout_d = 1'b0;

        if (cpu_posedge) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (cmd_active) begin
                        if (sel_wait != '0) begin
                            // count holds "waits still to go after this one"
                            count_d = sel_wait - COUNT_ONE;
                            state_d = ST_COUNT;
                        end else if (ch_rdy) begin
                            state_d = ST_DONE;
                        end else begin
                            tcount_d = '0;
                            state_d  = ST_WAIT_CHANNEL;
                        end
                    end
                end

                ST_COUNT: begin
                    if (!cmd_active) begin
                        // CPU abandoned the cycle; drop straight back
                        state_d = ST_IDLE;
                    end else if (count_q != '0) begin
                        count_d = count_q - COUNT_ONE;
                    end else if (ch_rdy) begin
                        state_d = ST_DONE;
                    end else begin
                        tcount_d = '0;
                        state_d  = ST_WAIT_CHANNEL;
                    end
                end

                ST_WAIT_CHANNEL: begin
                    if (!cmd_active) begin
                        state_d = ST_IDLE;
                    end else if (ch_rdy) begin
                        state_d = ST_DONE;
                    end else if (TIMEOUT_EN && (tcount_q == TCOUNT_LAST)) begin
                        state_d        = ST_DONE;
                        wait_timeout_d = 1'b1;
                    end else if (tcount_q != '1) begin
                        // Saturating: with the watchdog disabled the counter
                        // parks at all-ones instead of wrapping.
                        tcount_d = tcount_q + TCOUNT_ONE;
                    end
                end

                ST_DONE: begin
                    // Hold here until the strobe is released, so a command
                    // still low when we return to IDLE is not counted twice.
                    if (!cmd_active) begin
                        state_d = ST_IDLE;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sequencer: outputs
    // ------------------------------------------------------------------
    logic stall_cpu;
    logic ready_q;

    always_comb begin
        stall_cpu = state_stalls_cpu(state_q);
        bus_busy  = (state_q != ST_IDLE);
    end

    // READY follows 8284 timing: it only changes on CPU falling edges, so it
    // is stable around every CPU rising edge where the CPU samples it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ready_q <= 1'b1;
        end else if (cpu_negedge) begin
            ready_q <= ~stall_cpu;
        end
    end

    assign ready        = ready_q;
    assign wait_timeout = wait_timeout_q;

endmodule

// File: tb/tb_bus_ready_generator.sv
// Self-checking bench for bus_ready_generator: directed scenarios plus
// randomized command/channel traffic compared every clock to a transaction
// model of the ready-insertion rules.
`timescale 1ns/1ps
module tb_bus_ready_generator;

    localparam int IO_WS  = 2;
    localparam int MEM_WS = 0;
    localparam int TO_CYC = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic cpu_clock = 1'b0;
    logic io_read_command_n = 1'b1;
    logic io_write_command_n = 1'b1;
    logic interrupt_acknowledge_n = 1'b1;
    logic memory_read_command_n = 1'b1;
    logic memory_write_command_n = 1'b1;
    logic io_channel_ready = 1'b1;
    logic ready;
    logic wait_timeout;
    logic bus_busy;

    int n_tests = 0;
    int n_fail = 0;
    int lows = 0;
    int pulse_cnt = 0;
    bit chk_en = 1'b0;

    always #5 clock = ~clock;

    bus_ready_generator #(
        .IO_WAIT_STATES  (IO_WS),
        .MEM_WAIT_STATES (MEM_WS),
        .TIMEOUT_CYCLES  (TO_CYC)
    ) dut (
        .clock                   (clock),
        .reset                   (reset),
        .cpu_clock               (cpu_clock),
        .io_read_command_n       (io_read_command_n),
        .io_write_command_n      (io_write_command_n),
        .interrupt_acknowledge_n (interrupt_acknowledge_n),
        .memory_read_command_n   (memory_read_command_n),
        .memory_write_command_n  (memory_write_command_n),
        .io_channel_ready        (io_channel_ready),
        .ready                   (ready),
        .wait_timeout            (wait_timeout),
        .bus_busy                (bus_busy)
    );

    task automatic check(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Transaction model. A bus cycle is "in progress" from the CPU rising
    // edge that first sees a command until the rising edge that sees it
    // released. Within it, the CPU is stalled while fixed waits remain or
    // while the channel is being polled; once released it stays complete.
    // ------------------------------------------------------------------
    bit m_prev = 1'b0;
    bit m_sync [2] = '{1'b1, 1'b1};
    bit m_ready = 1'b1;
    bit m_timeout = 1'b0;
    bit m_in_txn = 1'b0;
    bit m_complete = 1'b0;
    bit m_on_channel = 1'b0;
    int m_waits_left = 0;
    int m_chan_polls = 0;
    bit m_rise, m_fall, m_ch, m_io, m_mem, m_act;

    task automatic m_check_channel();
        if (m_ch) begin
            m_complete = 1'b1;
        end else begin
            m_on_channel = 1'b1;
            m_chan_polls = 0;
        end
    endtask

    initial begin
        forever begin
            @(posedge clock or posedge reset);
            if (reset) begin
                m_prev = 1'b0;
                m_sync[0] = 1'b1;
                m_sync[1] = 1'b1;
                m_ready = 1'b1;
                m_timeout = 1'b0;
                m_in_txn = 1'b0;
                m_complete = 1'b0;
                m_on_channel = 1'b0;
                m_waits_left = 0;
                m_chan_polls = 0;
            end else begin
                m_rise = !m_prev && cpu_clock;
                m_fall = m_prev && !cpu_clock;
                m_ch = m_sync[1];
                m_io = !io_read_command_n || !io_write_command_n || !interrupt_acknowledge_n;
                m_mem = !memory_read_command_n || !memory_write_command_n;
                m_act = m_io || m_mem;
                m_timeout = 1'b0;
                if (m_fall) m_ready = !(m_in_txn && !m_complete);
                if (m_rise) begin
                    if (!m_in_txn) begin
                        if (m_act) begin
                            m_in_txn = 1'b1;
                            m_complete = 1'b0;
                            m_on_channel = 1'b0;
                            m_waits_left = m_io ? IO_WS : MEM_WS;
                            if (m_waits_left == 0) m_check_channel();
                        end
                    end else if (m_complete) begin
                        if (!m_act) m_in_txn = 1'b0;
                    end else if (!m_act) begin
                        m_in_txn = 1'b0;
                    end else if (!m_on_channel) begin
                        m_waits_left--;
                        if (m_waits_left == 0) m_check_channel();
                    end else if (m_ch) begin
                        m_complete = 1'b1;
                    end else if (m_chan_polls == TO_CYC - 1) begin
                        m_complete = 1'b1;
                        m_timeout = 1'b1;
                    end else begin
                        m_chan_polls++;
                    end
                end
                m_prev = cpu_clock;
                m_sync[1] = m_sync[0];
                m_sync[0] = io_channel_ready;
            end
        end
    end

    // Compare process: every clock, away from the active edge.
    initial begin
        forever begin
            @(negedge clock);
            if (chk_en) begin
                check("ready", ready, m_ready);
                check("bus_busy", bus_busy, m_in_txn);
                check("wait_timeout", wait_timeout, m_timeout);
                if (wait_timeout === 1'b1) pulse_cnt++;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    // One CPU clock period; READY is counted as the CPU would sample it on
    // the rising edge.
    task automatic cpu_cycle(input int h);
        if (ready === 1'b0) lows++;
        cpu_clock = 1'b1;
        repeat (h) tick();
        cpu_clock = 1'b0;
        repeat (h) tick();
    endtask

    // bit set = strobe asserted: {memw, memr, inta, iow, ior}
    task automatic set_cmd(input logic [4:0] v);
        io_read_command_n       = ~v[0];
        io_write_command_n      = ~v[1];
        interrupt_acknowledge_n = ~v[2];
        memory_read_command_n   = ~v[3];
        memory_write_command_n  = ~v[4];
    endtask

    initial begin
        tick();
        chk_en = 1'b1;
        repeat (2) tick();
        check("reset_ready", ready, 1'b1);
        check("reset_bus_busy", bus_busy, 1'b0);
        check("reset_wait_timeout", wait_timeout, 1'b0);
        reset = 1'b0;
        repeat (3) tick();

        // I/O read, channel ready: exactly IO_WS (2) stalled rising edges.
        lows = 0; pulse_cnt = 0;
        io_channel_ready = 1'b1;
        set_cmd(5'b00001);
        cpu_cycle(3);
        check("ior_busy_after_first_edge", bus_busy, 1'b1);
        repeat (3) cpu_cycle(3);
        set_cmd(5'b00000);
        repeat (2) cpu_cycle(3);
        check_int("ior_wait_states", lows, 2);
        check("ior_idle_after_release", bus_busy, 1'b0);

        // Memory read, zero waits: READY never drops, cycle still tracked.
        lows = 0;
        set_cmd(5'b01000);
        cpu_cycle(3);
        check("memr_busy_in_done", bus_busy, 1'b1);
        repeat (3) cpu_cycle(3);
        set_cmd(5'b00000);
        repeat (2) cpu_cycle(3);
        check_int("memr_wait_states", lows, 0);
        check("memr_idle_after_release", bus_busy, 1'b0);

        // I/O write with channel held off for 5 CPU clocks.
        lows = 0; pulse_cnt = 0;
        io_channel_ready = 1'b0;
        set_cmd(5'b00010);
        repeat (5) cpu_cycle(3);
        io_channel_ready = 1'b1;
        repeat (4) cpu_cycle(3);
        set_cmd(5'b00000);
        repeat (2) cpu_cycle(3);
        check_int("iow_channel_wait_states", lows, 6);
        check_int("iow_no_timeout", pulse_cnt, 0);

        // INTA with the channel stuck: watchdog releases after 8 polls.
        lows = 0; pulse_cnt = 0;
        io_channel_ready = 1'b0;
        set_cmd(5'b00100);
        repeat (14) cpu_cycle(3);
        set_cmd(5'b00000);
        io_channel_ready = 1'b1;
        repeat (2) cpu_cycle(3);
        check_int("inta_timeout_wait_states", lows, 10);
        check_int("inta_timeout_pulse_clocks", pulse_cnt, 1);

        // Reset while polling the channel.
        io_channel_ready = 1'b0;
        set_cmd(5'b00100);
        repeat (5) cpu_cycle(3);
        check("pre_reset_busy", bus_busy, 1'b1);
        check("pre_reset_ready", ready, 1'b0);
        reset = 1'b1;
        #1;
        check("mid_reset_ready", ready, 1'b1);
        check("mid_reset_bus_busy", bus_busy, 1'b0);
        check("mid_reset_wait_timeout", wait_timeout, 1'b0);
        set_cmd(5'b00000);
        io_channel_ready = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        repeat (3) tick();
        lows = 0;
        set_cmd(5'b10000);
        cpu_cycle(3);
        check("memw_after_reset_busy", bus_busy, 1'b1);
        repeat (2) cpu_cycle(3);
        set_cmd(5'b00000);
        repeat (2) cpu_cycle(3);
        check_int("memw_after_reset_wait_states", lows, 0);
        check("memw_after_reset_idle", bus_busy, 1'b0);

        // I/O read and memory write together: I/O count wins.
        lows = 0;
        set_cmd(5'b10001);
        repeat (4) cpu_cycle(3);
        set_cmd(5'b00000);
        repeat (2) cpu_cycle(3);
        check_int("precedence_wait_states", lows, 2);

        // Randomized traffic, checked by the model every clock.
        for (int t = 0; t < 200; t++) begin
            int hold;
            int gap;
            int h;
            int kind;
            int chmode;
            logic [4:0] cmdv;
            hold   = $urandom_range(0, 14);
            gap    = $urandom_range(1, 3);
            h      = $urandom_range(1, 3);
            kind   = $urandom_range(0, 6);
            chmode = $urandom_range(0, 3);
            case (kind)
                0: cmdv = 5'b00001;
                1: cmdv = 5'b00010;
                2: cmdv = 5'b00100;
                3: cmdv = 5'b01000;
                4: cmdv = 5'b10000;
                5: cmdv = 5'b10001;
                default: cmdv = 5'b01010;
            endcase
            set_cmd(cmdv);
            for (int c = 0; c < hold; c++) begin
                io_channel_ready = (chmode == 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
                cpu_cycle(h);
            end
            set_cmd(5'b00000);
            for (int c = 0; c < gap; c++) begin
                io_channel_ready = ($urandom_range(0, 1) != 0);
                cpu_cycle(h);
            end
        end

        repeat (4) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
